// File: rtl/univ_shift_reg_if.sv
// Data/control bundle for univ_shift_reg: shift controls and load data in,
// register contents and framing status out.
interface univ_shift_reg_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             en;
  logic             clr;
  logic             set;
  logic [1:0]       op;
  logic             serial_in;
  logic [WIDTH-1:0] par_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_valid;

  modport master (
    output en, clr, set, op, serial_in, par_in,
    input  q, serial_out, bit_cnt, word_valid
  );

  modport slave (
    input  en, clr, set, op, serial_in, par_in,
    output q, serial_out, bit_cnt, word_valid
  );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with a frame
// counter that pulses word_valid once every WIDTH shifts.
module univ_shift_reg #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  univ_shift_reg_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  localparam logic [1:0] OpHold  = 2'b00;
  localparam logic [1:0] OpRight = 2'b01;
  localparam logic [1:0] OpLeft  = 2'b10;
  localparam logic [1:0] OpLoad  = 2'b11;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] OneCnt  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             so_q, so_d;
  logic             wv_q, wv_d;
  logic             shift;

  // Data path: clr beats set beats op; everything gated by en.
  always_comb begin
    q_d   = q_q;
    so_d  = so_q;
    shift = 1'b0;
    if (bus.en) begin
      if (bus.clr) begin
        q_d = '0;
      end else if (bus.set) begin
        q_d = '1;
      end else begin
        unique case (bus.op)
          OpHold: ;
          OpRight: begin
            q_d   = {bus.serial_in, q_q[WIDTH-1:1]};
            so_d  = q_q[0];
            shift = 1'b1;
          end
          OpLeft: begin
            q_d   = {q_q[WIDTH-2:0], bus.serial_in};
            so_d  = q_q[WIDTH-1];
            shift = 1'b1;
          end
          OpLoad: q_d = bus.par_in;
        endcase
      end
    end
  end

  // Frame FSM: any clr/set/load restarts the frame; the WIDTH-th shift completes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wv_d    = 1'b0;
    if (bus.en && (bus.clr || bus.set || (bus.op == OpLoad))) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (shift) begin
      unique case (state_q)
        StIdle: begin
          state_d = StFill;
          cnt_d   = OneCnt;
        end
        StFill: begin
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
            cnt_d   = '0;
            wv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + OneCnt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      so_q    <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      so_q    <= so_d;
      wv_q    <= wv_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.serial_out = so_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.word_valid = wv_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: WIDTH=4 and WIDTH=8 instances share one stimulus
// stream; both are checked each cycle against an arithmetic reference model.
module tb_univ_shift_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(4)) if4 ();
  univ_shift_reg_if #(.WIDTH(8)) if8 ();

  univ_shift_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  univ_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  int checks = 0;
  int errors = 0;

  // Reference state per instance: index 0 is WIDTH=4, index 1 is WIDTH=8.
  int unsigned wid [2] = '{4, 8};
  int unsigned mq  [2];
  int unsigned mso [2];
  int unsigned mcnt[2];
  int unsigned mwv [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic c, input logic s,
                              input logic [1:0] o, input logic si, input logic [7:0] p);
    for (int d = 0; d < 2; d++) begin
      int unsigned w    = wid[d];
      int unsigned mask = (1 << w) - 1;
      if (r) begin
        mq[d] = 0; mso[d] = 0; mcnt[d] = 0; mwv[d] = 0;
      end else if (!e) begin
        mwv[d] = 0;
      end else if (c) begin
        mq[d] = 0; mcnt[d] = 0; mwv[d] = 0;
      end else if (s) begin
        mq[d] = mask; mcnt[d] = 0; mwv[d] = 0;
      end else if (o == 2'd3) begin
        mq[d] = p & mask; mcnt[d] = 0; mwv[d] = 0;
      end else if (o == 2'd0) begin
        mwv[d] = 0;
      end else begin
        if (o == 2'd1) begin
          mso[d] = mq[d] & 1;
          mq[d]  = (mq[d] >> 1) | (int'(si) << (w - 1));
        end else begin
          mso[d] = (mq[d] >> (w - 1)) & 1;
          mq[d]  = ((mq[d] << 1) | int'(si)) & mask;
        end
        mcnt[d] = (mcnt[d] + 1) % w;
        mwv[d]  = (mcnt[d] == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic s,
                      input logic [1:0] o, input logic si, input logic [7:0] p);
    rst = r;
    if4.en = e; if4.clr = c; if4.set = s; if4.op = o; if4.serial_in = si;
    if4.par_in = p[3:0];
    if8.en = e; if8.clr = c; if8.set = s; if8.op = o; if8.serial_in = si;
    if8.par_in = p;
    model_update(r, e, c, s, o, si, p);
    @(posedge clk);
    #1;
    check("w4_q",   32'(if4.q),          mq[0]);
    check("w4_so",  32'(if4.serial_out), mso[0]);
    check("w4_cnt", 32'(if4.bit_cnt),    mcnt[0]);
    check("w4_wv",  32'(if4.word_valid), mwv[0]);
    check("w8_q",   32'(if8.q),          mq[1]);
    check("w8_so",  32'(if8.serial_out), mso[1]);
    check("w8_cnt", 32'(if8.bit_cnt),    mcnt[1]);
    check("w8_wv",  32'(if8.word_valid), mwv[1]);
  endtask

  logic [3:0] sr_bits;
  logic [3:0] exp_q4 [4];
  logic [7:0] frame;

  initial begin
    rst = 1'b1;
    if4.en = 0; if4.clr = 0; if4.set = 0; if4.op = 0; if4.serial_in = 0; if4.par_in = 0;
    if8.en = 0; if8.clr = 0; if8.set = 0; if8.op = 0; if8.serial_in = 0; if8.par_in = 0;

    // Reset with arbitrary inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
           8'($urandom));
    check("rst_q", 32'(if4.q), 32'h0);
    check("rst_so", 32'(if4.serial_out), 32'h0);
    check("rst_cnt", 32'(if4.bit_cnt), 32'h0);
    check("rst_wv", 32'(if4.word_valid), 32'h0);

    // Right shifts of 1,0,1,1
    sr_bits = 4'b1101;
    exp_q4  = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, sr_bits[i], 8'h00);
      check("sr_q", 32'(if4.q), 32'(exp_q4[i]));
      check("sr_cnt", 32'(if4.bit_cnt), (i + 1) % 4);
      check("sr_wv", 32'(if4.word_valid), (i == 3) ? 1 : 0);
    end

    // Load 1001 then shift left with zeros
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 8'h09);
    check("ld_q", 32'(if4.q), 32'h9);
    check("ld_wv", 32'(if4.word_valid), 32'h0);
    sr_bits = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 8'h00);
      check("sl_so", 32'(if4.serial_out), 32'(sr_bits[3 - i]));
      check("sl_wv", 32'(if4.word_valid), (i == 3) ? 1 : 0);
    end
    check("sl_q", 32'(if4.q), 32'h0);

    // Set and clear together clears; set alone fills ones
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 8'h06);
    check("pre_q", 32'(if4.q), 32'h6);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
    check("clrset_q", 32'(if4.q), 32'h0);
    check("clrset_cnt", 32'(if4.bit_cnt), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    check("set_q", 32'(if4.q), 32'hF);

    // Two shifts, enable low holds, then reset
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 8'h00);
    check("two_cnt", 32'(if4.bit_cnt), 32'h2);
    check("two_q", 32'(if4.q), 32'h3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
      check("hold_q", 32'(if4.q), 32'h3);
      check("hold_cnt", 32'(if4.bit_cnt), 32'h2);
      check("hold_so", 32'(if4.serial_out), 32'h1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 8'h00);
    check("rst2_q", 32'(if4.q), 32'h0);
    check("rst2_cnt", 32'(if4.bit_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
      check("rst2_wv", 32'(if4.word_valid), 32'h0);
    end

    // WIDTH=8: continuous frames 0xA5 then 0x3C, LSB first
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      frame = (i < 8) ? 8'hA5 : 8'h3C;
      step(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, frame[i % 8], 8'h00);
      check("w8_frame_wv", 32'(if8.word_valid), (i == 7 || i == 15) ? 1 : 0);
      if (i == 7)  check("w8_frame_a5", 32'(if8.q), 32'hA5);
      if (i == 15) check("w8_frame_3c", 32'(if8.q), 32'h3C);
    end

    // Randomised traffic, shifts weighted heavily
    for (int i = 0; i < 400; i++) begin
      logic [1:0] o;
      o = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'($urandom_range(1, 2));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0), o,
           1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
